aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES round sequencer. Holds the 128-bit cipher state and steps it through NR+1 round passes of an external combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey).
- Drives the round number to the key-schedule lookup and the per-round enables (skip S-box on the whitening round, skip MixColumns on whitening and final rounds).
- Sits between the block-level valid/ready interface and the round datapath. One block in flight at a time.

Parameters:
- NR, 10, number of AES rounds; legal values 10/12/14 (AES-128/192/256).
- RW, 4, width of rnd_num; must satisfy 2^RW > NR.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext block offered
- in_ready  output  1  controller can accept a block
- in_data  input  128  block to process
- abort  input  1  synchronous cancel of the block in flight
- rnd_state  output  128  current state to round datapath (equals state register)
- rnd_num  output  RW  round index to datapath/key schedule
- rnd_sub_en  output  1  datapath applies SubBytes+ShiftRows this pass
- rnd_mix_en  output  1  datapath applies MixColumns this pass
- rnd_data  input  128  datapath result for rnd_state/rnd_num (combinational, same cycle)
- out_valid  output  1  result block available
- out_ready  input  1  consumer accepts result
- out_data  output  128  result block (equals state register)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, state register=0, rnd_num=0, out_valid=0, busy=0. in_ready is 1 once rst_n is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state<=in_data, rnd_num<=0, go to RUN.
- RUN:
  - in_ready=0. Each cycle: state<=rnd_data, rnd_num<=rnd_num+1.
  - When rnd_num==NR: state<=rnd_data, rnd_num<=0, go to DONE.
  - RUN lasts exactly NR+1 cycles.
- DONE:
  - out_valid=1 and out_data stable until out_ready.
  - On out_ready: go to IDLE. in_ready returns the next cycle; no same-cycle reaccept.
- Latency: out_valid rises NR+1 cycles after the accepting edge (11 for NR=10). Throughput: one block per NR+3 cycles minimum.
- Enables are combinational from rnd_num and FSM state:
  - rnd_sub_en = RUN && rnd_num!=0.
  - rnd_mix_en = RUN && rnd_num!=0 && rnd_num!=NR.
  - Outside RUN both are 0.
- abort:
  - In RUN: go to IDLE next edge; state unchanged; rnd_num<=0; no out_valid.
  - In DONE: abort wins over out_ready; block is discarded.
  - In IDLE: ignored; in_valid acceptance still occurs.
- rnd_num never exceeds NR. No wrap: the counter is cleared on the RUN→DONE transition.
- in_valid while busy is ignored (not queued). The producer must hold it until in_ready.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the in-flight block is lost.

Optional Feature:
- Macro: AES_ROUND_CTRL_DEC_EN.
- Defined:
  - Adds input in_dec (1 bit, sampled at acceptance) and output rnd_dec (registered copy, held for the whole block).
  - When rnd_dec=1: rnd_num starts at NR and counts down to 0. DONE is entered after the rnd_num==0 pass.
  - rnd_sub_en = RUN && rnd_num!=NR.
  - rnd_mix_en = RUN && rnd_num!=0 && rnd_num!=NR (datapath selects inverse functions by rnd_dec).
  - Latency is unchanged.
- Undefined: encrypt-only; ports in_dec/rnd_dec absent.

Test Plan:
- FIPS-197 App. B, NR=10, bench reference round datapath + key schedule, key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32. out_valid exactly 11 cycles after accept. rnd_num sequence 0..10. rnd_mix_en sequence 0,1×9,0. rnd_sub_en 0,1×10.
- Backpressure: out_ready held low 5 cycles in DONE -> out_valid=1 and out_data constant throughout, in_ready=0, second in_valid ignored. After out_ready pulse, in_ready=1 next cycle and second block accepted and correct.
- Abort at rnd_num==4 -> IDLE next cycle, out_valid never rises, rnd_num=0. A following block (all-zero key, all-zero in_data) -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Reset mid-RUN (rst_n low at rnd_num==7, asynchronous, between edges) -> busy=0, out_valid=0, state=0 immediately. After release, a normal block completes correctly.
- Back-to-back: in_valid held high with two blocks -> accepts spaced exactly NR+3=13 cycles apart with out_ready tied high. Both results match the reference.
- AES_ROUND_CTRL_DEC_EN: in_dec=1, in_data 3925841d02dc09fbdc118597196a0b32, App. B key -> 3243f6a8885a308d313198a2e0370734. rnd_num 10 down to 0. rnd_sub_en 0,1×10.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer, one block in flight.
// Optional decrypt direction (in_dec/rnd_dec) when AES_ROUND_CTRL_DEC_EN is defined.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
`ifdef AES_ROUND_CTRL_DEC_EN
    input  logic          in_dec,
    output logic          rnd_dec,
`endif
    input  logic          abort,
    output logic [127:0]  rnd_state,
    output logic [RW-1:0] rnd_num,
    output logic          rnd_sub_en,
    output logic          rnd_mix_en,
    input  logic [127:0]  rnd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [RW-1:0] LP_NR   = RW'(NR);
    localparam logic [RW-1:0] LP_ZERO = '0;
    localparam logic [RW-1:0] LP_ONE  = RW'(1);

    state_t        r_fsm;
    state_t        w_fsm_nxt;
    logic [127:0]  r_state;
    logic [RW-1:0] r_rnd;
    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic [RW-1:0] w_rnd_first;
    logic [RW-1:0] w_rnd_step;

    assign w_run    = (r_fsm == S_RUN);
    assign in_ready = (r_fsm == S_IDLE);
    assign w_accept = in_valid && in_ready;

`ifdef AES_ROUND_CTRL_DEC_EN
    logic r_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec <= 1'b0;
        end else if (w_accept) begin
            r_dec <= in_dec;
        end
    end

    // Decrypt walks the key schedule backwards, NR down to 0
    assign rnd_dec     = r_dec;
    assign w_rnd_first = in_dec ? LP_NR : LP_ZERO;
    assign w_rnd_step  = r_dec ? (r_rnd - LP_ONE) : (r_rnd + LP_ONE);
    assign w_last      = r_dec ? (r_rnd == LP_ZERO) : (r_rnd == LP_NR);
    assign rnd_sub_en  = w_run && (r_dec ? (r_rnd != LP_NR)
                                         : (r_rnd != LP_ZERO));
`else
    assign w_rnd_first = LP_ZERO;
    assign w_rnd_step  = r_rnd + LP_ONE;
    assign w_last      = (r_rnd == LP_NR);
    assign rnd_sub_en  = w_run && (r_rnd != LP_ZERO);
`endif

    assign rnd_mix_en = w_run && (r_rnd != LP_ZERO) && (r_rnd != LP_NR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // abort outranks both the final pass and the output handshake
    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            S_IDLE: begin
                if (w_accept) begin
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_fsm_nxt = S_IDLE;
                end else if (w_last) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_rnd   <= '0;
        end else if (w_accept) begin
            r_state <= in_data;
            r_rnd   <= w_rnd_first;
        end else if (w_run) begin
            if (abort) begin
                r_rnd <= '0;
            end else begin
                r_state <= rnd_data;
                r_rnd   <= w_last ? LP_ZERO : w_rnd_step;
            end
        end
    end

    assign rnd_state = r_state;
    assign out_data  = r_state;
    assign rnd_num   = r_rnd;
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl, with a reference
// AES-128 round datapath and key schedule answering rnd_data.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2    = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic [127:0]  in_data = '0;
    logic          in_ready, rnd_sub_en, rnd_mix_en, out_valid, busy;
    logic [127:0]  rnd_state, rnd_data, out_data;
    logic [RW-1:0] rnd_num;
    logic          w_dec;

`ifdef AES_ROUND_CTRL_DEC_EN
    logic in_dec = 1'b0;
    logic rnd_dec;
    assign w_dec = rnd_dec;
`else
    assign w_dec = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] sb[$];
    logic [127:0] rk[0:15];

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef AES_ROUND_CTRL_DEC_EN
        .in_dec(in_dec),
        .rnd_dec(rnd_dec),
`endif
        .abort(abort),
        .rnd_state(rnd_state),
        .rnd_num(rnd_num),
        .rnd_sub_en(rnd_sub_en),
        .rnd_mix_en(rnd_mix_en),
        .rnd_data(rnd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, b;
        r = 8'h01; b = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] t;
        t = b;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (!inv) begin
                o[127-32*c -: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                o[103-32*c -: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
            end else begin
                o[127-32*c -: 8] = gmul(a0,14) ^ gmul(a1,11) ^ gmul(a2,13) ^ gmul(a3,9);
                o[119-32*c -: 8] = gmul(a0,9) ^ gmul(a1,14) ^ gmul(a2,11) ^ gmul(a3,13);
                o[111-32*c -: 8] = gmul(a0,13) ^ gmul(a1,9) ^ gmul(a2,14) ^ gmul(a3,11);
                o[103-32*c -: 8] = gmul(a0,11) ^ gmul(a1,13) ^ gmul(a2,9) ^ gmul(a3,14);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_pass(input logic [127:0] s, input logic [127:0] k,
                                              input logic sub, input logic mix, input logic dec);
        logic [127:0] t;
        t = s;
        if (!dec) begin
            if (sub) t = shift_rows(sub_bytes(t, 1'b0), 1'b0);
            if (mix) t = mix_cols(t, 1'b0);
            t = t ^ k;
        end else begin
            if (sub) t = sub_bytes(shift_rows(t, 1'b1), 1'b1);
            t = t ^ k;
            if (mix) t = mix_cols(t, 1'b1);
        end
        return t;
    endfunction

    assign rnd_data = aes_pass(rnd_state, rk[rnd_num], rnd_sub_en, rnd_mix_en, w_dec);

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w[0:43];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= NR) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else rk[r] = '0;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        acc      = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            if (in_ready) acc = cyc;
            tick();
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready %0b, required 1 within 40 cycles", in_ready);
        end
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d blocks pending, required 0", sb.size());
        end
    endtask

    // Monitor: every accepted result is compared against the scoreboard head
    initial begin : monitor
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !abort) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: out_data %h, required no output", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL out_data: got %h, required %h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin : stim
        int a1, a2;
        logic [127:0] ref_st;

        set_key(KEY_B);
        #1 rst_n = 1'b0;
        #11;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rnd_num", rnd_num, 0);
        chk("rst_state", rnd_state, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // FIPS-197 App. B with full sequence checks
        sb.push_back(CT_B);
        send(PT_B, a1);
        for (int i = 0; i <= NR; i++) begin
            chk("rnd_num", rnd_num, i);
            chk("sub_en", rnd_sub_en, (i != 0));
            chk("mix_en", rnd_mix_en, (i != 0 && i != NR));
            chk("run_out_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            tick();
        end
        chk("latency_out_valid", out_valid, 1);
        chk("done_sub_en", rnd_sub_en, 0);
        tick();
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);

        // Backpressure in DONE, second offer ignored until handshake
        out_ready = 1'b0;
        sb.push_back(C1);
        send(P1, a1);
        repeat (NR + 1) tick();
        in_valid = 1'b1;
        in_data  = P2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, C1);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        sb.push_back(C2);
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_ret", in_ready, 1);
        chk("bp_out_valid_low", out_valid, 0);
        send(P2, a2);
        chk("bp_second_busy", busy, 1);
        out_ready = 1'b1;
        wait_done(40);

        // Abort at round 4: state held, no output
        send(P1, a1);
        repeat (4) tick();
        ref_st = P1;
        for (int r = 0; r < 4; r++)
            ref_st = aes_pass(ref_st, rk[r], (r != 0), (r != 0 && r != NR), 1'b0);
        chk("ab_rnd_num4", rnd_num, 4);
        chk("ab_state4", rnd_state, ref_st);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_in_ready", in_ready, 1);
        chk("ab_rnd_num", rnd_num, 0);
        chk("ab_state_held", rnd_state, ref_st);
        repeat (15) tick();
        chk("ab_no_out_valid", out_valid, 0);

        // Zero key block; abort while idle must not block acceptance
        set_key('0);
        sb.push_back(CT_Z);
        abort = 1'b1;
        send('0, a1);
        abort = 1'b0;
        chk("ab_idle_accept", busy, 1);
        wait_done(40);

        // Abort in DONE wins over out_ready
        out_ready = 1'b0;
        send('0, a1);
        repeat (NR + 1) tick();
        chk("abd_out_valid", out_valid, 1);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("abd_dropped", out_valid, 0);
        chk("abd_busy", busy, 0);

        // Asynchronous reset at round 7
        set_key(KEY_B);
        send(P1, a1);
        repeat (7) tick();
        chk("rr_rnd_num7", rnd_num, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_state", rnd_state, 0);
        chk("rr_rnd_num", rnd_num, 0);
        tick();
        #2 rst_n = 1'b1;
        set_key(KEY_C);
        sb.push_back(CT_C);
        send(PT_C, a1);
        wait_done(40);

        // Back-to-back with in_valid held
        set_key(KEY_B);
        out_ready = 1'b1;
        sb.push_back(C1);
        sb.push_back(C2);
        send(P1, a1);
        send(P2, a2);
        chk("b2b_spacing", a2 - a1, NR + 3);
        wait_done(40);

`ifdef AES_ROUND_CTRL_DEC_EN
        in_dec = 1'b1;
        sb.push_back(PT_B);
        send(CT_B, a1);
        in_dec = 1'b0;
        for (int i = 0; i <= NR; i++) begin
            chk("dec_rnd_num", rnd_num, NR - i);
            chk("dec_sub_en", rnd_sub_en, (i != 0));
            chk("dec_mix_en", rnd_mix_en, (i != 0 && i != NR));
            chk("dec_flag", rnd_dec, 1);
            tick();
        end
        chk("dec_out_valid", out_valid, 1);
        wait_done(40);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
